// File: rtl/crc_serial_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : crc_serial_checker_if
// Purpose  : Serial codeword in / recovered word out bundle for the CRC checker.
//            Stats signals exist only when CRC_CHECK_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface crc_serial_checker_if #(
    parameter int DATA_W = 10
) ();
    logic              bit_in;
    logic              bit_valid;
    logic              sof;
    logic [DATA_W-1:0] data_out;
    logic              crc_ok;
    logic              frame_valid;
    logic              busy;
    logic              abort;
`ifdef CRC_CHECK_STATS_EN
    logic              stats_clr;
    logic [15:0]       frame_cnt;
    logic [15:0]       err_cnt;

    modport master (
        output bit_in, bit_valid, sof, stats_clr,
        input  data_out, crc_ok, frame_valid, busy, abort, frame_cnt, err_cnt
    );
    modport slave (
        input  bit_in, bit_valid, sof, stats_clr,
        output data_out, crc_ok, frame_valid, busy, abort, frame_cnt, err_cnt
    );
`else
    modport master (
        output bit_in, bit_valid, sof,
        input  data_out, crc_ok, frame_valid, busy, abort
    );
    modport slave (
        input  bit_in, bit_valid, sof,
        output data_out, crc_ok, frame_valid, busy, abort
    );
`endif
endinterface
`default_nettype wire

// File: rtl/crc_serial_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_serial_checker
// Purpose  : Serial CRC checker, MSB first, generator 1+y+y^7+y^9; recovers the
//            message word and flags remainder==0. Optional stats: CRC_CHECK_STATS_EN.
// Revision : 1.0
// ============================================================================
module crc_serial_checker #(
    parameter int               DATA_W = 10,
    parameter int               CRC_W  = 9,
    parameter logic [CRC_W-1:0] POLY   = 9'h083
) (
    input  wire logic             clk,
    input  wire logic             reset,
    crc_serial_checker_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W + CRC_W + 1);
    localparam logic [CNT_W-1:0] C_DATA_LAST  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(DATA_W + CRC_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CRC_W-1:0]  rem_q;
    logic [DATA_W-1:0] msg_q;
    logic [DATA_W-1:0] data_out_q;
    logic              crc_ok_q;
    logic              frame_valid_q;
    logic              abort_q;

    logic              feedback;
    logic [CRC_W-1:0]  rem_d;
    logic [CRC_W-1:0]  rem_sof_d;
    logic [CNT_W-1:0]  cnt_d;

    assign feedback  = bus.bit_in ^ rem_q[CRC_W-1];
    assign rem_d     = {rem_q[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
    // A start bit is folded into an all-zero remainder, leaving only its feedback term.
    assign rem_sof_d = bus.bit_in ? POLY : '0;
    assign cnt_d     = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            msg_q         <= '0;
            data_out_q    <= '0;
            crc_ok_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            abort_q       <= 1'b0;
            if (bus.bit_valid) begin
                if (bus.sof) begin
                    abort_q <= (state_q != S_IDLE);
                    rem_q   <= rem_sof_d;
                    msg_q   <= {{(DATA_W-1){1'b0}}, bus.bit_in};
                    cnt_q   <= CNT_W'(1);
                    state_q <= S_DATA;
                end else begin
                    case (state_q)
                        S_DATA: begin
                            msg_q <= {msg_q[DATA_W-2:0], bus.bit_in};
                            rem_q <= rem_d;
                            cnt_q <= cnt_d;
                            if (cnt_d == C_DATA_LAST) begin
                                state_q <= S_CHECK;
                            end
                        end
                        S_CHECK: begin
                            rem_q <= rem_d;
                            cnt_q <= cnt_d;
                            if (cnt_d == C_FRAME_LAST) begin
                                frame_valid_q <= 1'b1;
                                data_out_q    <= msg_q;
                                crc_ok_q      <= (rem_d == '0);
                                cnt_q         <= '0;
                                state_q       <= S_IDLE;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.abort       = abort_q;
    assign bus.busy        = (state_q != S_IDLE);

`ifdef CRC_CHECK_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    // Counters follow the frame_valid pulse; clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (bus.stats_clr) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (frame_valid_q) begin
            if (frame_cnt_q != 16'hFFFF) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (!crc_ok_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_serial_checker
// Purpose  : Self-checking bench for crc_serial_checker using a polynomial
//            long-division reference model.
// Revision : 1.0
// ============================================================================
module tb_crc_serial_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crc_serial_checker_if bus_if ();

    crc_serial_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int ab_cnt = 0;

    // Pulse counters sample the value held through the previous cycle.
    always @(posedge clk) begin
        if (bus_if.frame_valid === 1'b1) fv_cnt++;
        if (bus_if.abort === 1'b1) ab_cnt++;
    end

    typedef struct {
        logic [9:0] data;
        logic [8:0] crc;
        int         stall;
        logic [9:0] exp_data;
        logic       exp_ok;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Remainder of a polynomial over GF(2) modulo g = y^9+y^7+y+1.
    function automatic logic [8:0] polymod(input logic [27:0] v);
        logic [27:0] r;
        logic [27:0] g;
        r = v;
        g = 28'h283;
        for (int i = 27; i >= 9; i--) begin
            if (r[i]) r = r ^ (g << (i - 9));
        end
        return r[8:0];
    endfunction

    function automatic logic [8:0] make_crc(input logic [9:0] d);
        return polymod({9'b0, d, 9'b0});
    endfunction

    function automatic logic model_ok(input logic [18:0] cw);
        return polymod({cw, 9'b0}) == 9'd0;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            bus_if.bit_valid = 1'b0;
            bus_if.bit_in    = 1'($urandom);
            bus_if.sof       = 1'($urandom);
            @(negedge clk);
        end
        bus_if.sof = 1'b0;
    endtask

    task automatic drive_bit(input logic b, input logic s);
        bus_if.bit_in    = b;
        bus_if.sof       = s;
        bus_if.bit_valid = 1'b1;
        @(negedge clk);
        bus_if.bit_valid = 1'b0;
        bus_if.sof       = 1'b0;
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'($urandom), (i == 0));
    endtask

    task automatic send_frame(input logic [18:0] cw, input int stall, input bit rnd,
                              input logic exp_ab, input string tag);
        int n;
        for (int i = 0; i < 19; i++) begin
            drive_bit(cw[18-i], (i == 0));
            if (i == 0) begin
                check({tag, " abort"}, 32'(bus_if.abort), 32'(exp_ab));
                check({tag, " busy"}, 32'(bus_if.busy), 32'd1);
            end
            if (i < 18) begin
                n = rnd ? $urandom_range(stall, 0) : stall;
                for (int k = 0; k < n; k++) begin
                    idle_cycles(1);
                    check({tag, " stall busy"}, 32'(bus_if.busy), 32'd1);
                end
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [9:0] ed, input logic eok);
        check({tag, " frame_valid"}, 32'(bus_if.frame_valid), 32'd1);
        check({tag, " data_out"}, 32'(bus_if.data_out), 32'(ed));
        check({tag, " crc_ok"}, 32'(bus_if.crc_ok), 32'(eok));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        int          c0;
        int          a0;
        int          exp_frames;
        int          exp_aborts;
        logic [9:0]  d;
        logic [18:0] cw;
        logic        ab;

        vecs[0] = '{data: 10'h000, crc: 9'h000, stall: 0, exp_data: 10'h000, exp_ok: 1'b1};
        vecs[1] = '{data: 10'h001, crc: 9'h083, stall: 0, exp_data: 10'h001, exp_ok: 1'b1};
        vecs[2] = '{data: 10'h001, crc: 9'h082, stall: 0, exp_data: 10'h001, exp_ok: 1'b0};
        vecs[3] = '{data: 10'h001, crc: 9'h083, stall: 3, exp_data: 10'h001, exp_ok: 1'b1};

        reset            = 1'b1;
        bus_if.bit_in    = 1'b0;
        bus_if.bit_valid = 1'b0;
        bus_if.sof       = 1'b0;
`ifdef CRC_CHECK_STATS_EN
        bus_if.stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset data_out", 32'(bus_if.data_out), 32'd0);
        check("reset crc_ok", 32'(bus_if.crc_ok), 32'd0);
        check("reset frame_valid", 32'(bus_if.frame_valid), 32'd0);
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset abort", 32'(bus_if.abort), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Bits without sof in IDLE are ignored.
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        check("idle ignore busy", 32'(bus_if.busy), 32'd0);

        for (int v = 0; v < 4; v++) begin
            c0 = fv_cnt;
            send_frame({vecs[v].data, vecs[v].crc}, vecs[v].stall, 1'b0, 1'b0, $sformatf("vec%0d", v));
            check_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ok);
            idle_cycles(1);
            check($sformatf("vec%0d pulse", v), 32'(bus_if.frame_valid), 32'd0);
            check($sformatf("vec%0d fv count", v), 32'(fv_cnt - c0), 32'd1);
        end

        // Abort after 5 bits, then a valid frame, then a back-to-back frame.
        a0 = ab_cnt;
        c0 = fv_cnt;
        send_partial(5);
        send_frame({10'h001, 9'h083}, 0, 1'b0, 1'b1, "abort");
        check_result("abort", 10'h001, 1'b1);
        send_frame({10'h2A5, make_crc(10'h2A5)}, 0, 1'b0, 1'b0, "b2b");
        check_result("b2b", 10'h2A5, 1'b1);
        idle_cycles(2);
        check("abort count", 32'(ab_cnt - a0), 32'd1);
        check("b2b fv count", 32'(fv_cnt - c0), 32'd2);

        // Reset in CHECK state.
        send_partial(14);
        reset = 1'b1;
        #1;
        check("midreset data_out", 32'(bus_if.data_out), 32'd0);
        check("midreset crc_ok", 32'(bus_if.crc_ok), 32'd0);
        check("midreset busy", 32'(bus_if.busy), 32'd0);
        check("midreset frame_valid", 32'(bus_if.frame_valid), 32'd0);
        check("midreset abort", 32'(bus_if.abort), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_frame({10'h3C1, make_crc(10'h3C1)}, 0, 1'b0, 1'b0, "postreset");
        check_result("postreset", 10'h3C1, 1'b1);
        idle_cycles(1);

        // Randomized frames against the polynomial model.
        exp_frames = 0;
        exp_aborts = 0;
        c0 = fv_cnt;
        a0 = ab_cnt;
        for (int it = 0; it < 60; it++) begin
            d  = 10'($urandom);
            cw = {d, make_crc(d)};
            if ($urandom_range(3, 0) == 0) cw[$urandom_range(18, 0)] ^= 1'b1;
            if ($urandom_range(4, 0) == 0) begin
                for (int k = 0; k < 3; k++) drive_bit(1'($urandom), 1'b0);
            end
            ab = 1'b0;
            if ($urandom_range(4, 0) == 0) begin
                send_partial($urandom_range(18, 1));
                ab = 1'b1;
                exp_aborts++;
            end
            send_frame(cw, 2, 1'b1, ab, $sformatf("rand%0d", it));
            check_result($sformatf("rand%0d", it), cw[18:9], model_ok(cw));
            exp_frames++;
            if ($urandom_range(1, 0) == 0) idle_cycles($urandom_range(3, 1));
        end
        idle_cycles(2);
        check("rand fv count", 32'(fv_cnt - c0), 32'(exp_frames));
        check("rand abort count", 32'(ab_cnt - a0), 32'(exp_aborts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_serial_checker.md
Name: crc_serial_checker

Overview:
- Receive-side counterpart to the pipelined serial CRC encoder.
- Consumes a serial codeword, MSB first: DATA_W message bits followed by CRC_W check bits.
- Recomputes the remainder over generator 1+y+y^7+y^9, then presents the recovered parallel message with a pass/fail flag.
- Sits between the serial link deserialiser and the word-level consumer.

Parameters:
- DATA_W, 10: message bits per frame.
- CRC_W, 9: check bits per frame; also the generator degree.
- POLY, 9'h083: generator coefficients y^8..y^0 with the implicit y^9 term excluded (1+y+y^7+y^9).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- bit_in  in  1  serial codeword bit
- bit_valid  in  1  bit_in is valid this cycle; low stalls the block with no state change
- sof  in  1  start of frame; qualified by bit_valid; the accompanying bit_in is message bit DATA_W-1
- data_out  out  DATA_W  recovered message, MSB = first received bit
- crc_ok  out  1  remainder was zero for the frame in data_out
- frame_valid  out  1  one-cycle pulse: data_out and crc_ok updated
- busy  out  1  frame in progress (state != IDLE)
- abort  out  1  one-cycle pulse: a frame was restarted by sof before completion

Behaviour:
- Reset values: data_out=0, crc_ok=0, frame_valid=0, busy=0, abort=0; remainder=0; bit counter=0; state=IDLE.
- States: IDLE, DATA, CHECK.
- An accepted bit is any cycle with bit_valid=1 while the FSM is ready for it; non-IDLE states always accept.
- Remainder update on each accepted codeword bit:
  - fb = bit_in ^ rem[CRC_W-1]
  - rem <= {rem[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0)
  - Effective remainder = codeword * y^CRC_W mod g; zero iff the codeword is valid.
- IDLE:
  - bit_valid&sof: remainder loaded as if the bit were shifted into rem=0; shift register takes bit_in; cnt=1; go to DATA.
  - bit_valid without sof: ignored.
- DATA:
  - Each accepted bit shifts into the message register and the remainder; cnt increments.
  - On the bit that makes cnt==DATA_W, go to CHECK.
- CHECK:
  - Each accepted bit updates the remainder only; cnt increments.
  - On the bit where cnt reaches DATA_W+CRC_W, the next cycle produces:
    - frame_valid=1
    - data_out = message register
    - crc_ok = (next remainder == 0)
    - state -> IDLE
- Latency: frame_valid is asserted the cycle after the final CRC bit is accepted.
- Back-to-back frames: sof with bit_valid may arrive in the cycle where frame_valid is high (FSM already IDLE) and is accepted with no gap.
- data_out and crc_ok hold their values until the next frame_valid. An aborted frame never updates them.
- sof&bit_valid in DATA or CHECK:
  - abort pulses next cycle.
  - The current frame is discarded.
  - The new frame starts with this bit, cnt=1, state=DATA.
- Stalls: bit_valid=0 in any state holds all state and counters. Stall length is unbounded; there is no timeout.
- Reset asserted mid-frame: immediate return to reset values; no frame_valid or abort is issued.
- Counter width: $clog2(DATA_W+CRC_W+1).

Optional Feature:
- Macro: CRC_CHECK_STATS_EN.
- When defined:
  - Adds input stats_clr (1) and outputs frame_cnt (16) and err_cnt (16).
  - frame_cnt increments on every frame_valid.
  - err_cnt increments on frame_valid with crc_ok=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - stats_clr zeroes both synchronously and wins over a same-cycle increment.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Zero frame: sof, 19 bits of 0, continuous bit_valid -> frame_valid one cycle after the 19th bit; data_out=10'h000; crc_ok=1.
- Known vector: data 10'b0000000001, CRC 9'b010000011 (0x083), continuous -> data_out=10'h001; crc_ok=1.
- Error detection: same frame with CRC bit 0 flipped (0x082) -> crc_ok=0; data_out=10'h001. With stats enabled, err_cnt=1 and frame_cnt=1.
- Stalls: 0x001/0x083 frame with bit_valid low for 3 cycles between every bit -> identical result; frame_valid exactly once; busy high throughout.
- Abort and back-to-back:
  - sof mid-frame after 5 bits, then a full valid 0x001 frame -> abort pulse once, then frame_valid with crc_ok=1.
  - A second sof in the frame_valid cycle is accepted with no gap.
- Reset during CHECK -> all outputs return to 0 immediately; the next full valid frame is decoded correctly.
